// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory responder: command opcodes, address
// length and the frame-level state encoding.
package spi_mem_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam int         SPI_ADDR_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the last two synchronized samples.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_sr;
  logic                   prev;

  // Chain and history reset low so no edge can be reported before a real sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= '0;
      prev    <= 1'b0;
    end else begin
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], din};
      prev    <= sync_sr[SYNC_STAGES-1];
    end
  end

  assign dout = sync_sr[SYNC_STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 memory responder: serves READ/WRITE with a 24-bit address from an
// internal byte array, oversampling the bus in the clk domain.
module spi_ram_responder
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              active,
  output logic              cmd_err
);

  localparam int         DEPTH     = 2**ADDR_W;
  localparam logic [4:0] BYTE_LAST = 5'd7;
  localparam logic [4:0] BYTE_DONE = 5'd8;
  localparam logic [4:0] ADDR_LAST = 5'(SPI_ADDR_BITS - 1);

  logic [7:0]             mem [DEPTH];
  state_t                 state, state_d;
  logic                   sck_unused, sck_rise, sck_fall;
  logic                   cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   mosi_s;
  logic                   armed, is_rd, spi_we;
  logic [4:0]             bit_cnt;
  logic [ADDR_W-1:0]      addr, rd_addr;
  logic [6:0]             shift_in;
  logic [7:0]             in_byte, rd_shift, rd_byte;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .din(sck),
    .dout(sck_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sr <= '0;
    else        mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s  = mosi_sr[SYNC_STAGES-1];
  assign in_byte = {shift_in, mosi_s};
  // After a full byte the next read comes from addr+1, giving seamless bursts.
  assign rd_addr = (bit_cnt == BYTE_DONE) ? addr + 1'b1 : addr;
  assign rd_byte = mem[rd_addr];
  assign spi_we  = (state == WR_DATA) && sck_rise && (bit_cnt == BYTE_LAST) && !cs_rise;
  // Until cs_n has been seen high after reset, a held-low select is not a frame.
  assign active  = armed & ~cs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_d = CMD;
        CMD:     if (sck_rise && bit_cnt == BYTE_LAST)
                   state_d = (in_byte == SPI_CMD_READ || in_byte == SPI_CMD_WRITE) ? ADDR : IGNORE;
        ADDR:    if (sck_rise && bit_cnt == ADDR_LAST)
                   state_d = is_rd ? RD_DATA : WR_DATA;
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      is_rd    <= 1'b0;
      bit_cnt  <= '0;
      addr     <= '0;
      shift_in <= '0;
      rd_shift <= '0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      if (cs_s) armed <= 1'b1;
      if (cs_rise) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (cs_fall) bit_cnt <= '0;
          CMD: if (sck_rise) begin
            shift_in <= in_byte[6:0];
            if (bit_cnt == BYTE_LAST) begin
              bit_cnt <= '0;
              is_rd   <= (in_byte == SPI_CMD_READ);
              if (in_byte != SPI_CMD_READ && in_byte != SPI_CMD_WRITE) cmd_err <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ADDR: if (sck_rise) begin
            addr    <= {addr[ADDR_W-2:0], mosi_s};
            bit_cnt <= (bit_cnt == ADDR_LAST) ? '0 : bit_cnt + 1'b1;
          end
          RD_DATA: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (sck_fall) begin
              // bit_cnt==0 only on the very first falling edge of the data phase.
              if (bit_cnt == '0 || bit_cnt == BYTE_DONE) begin
                miso     <= rd_byte[7];
                rd_shift <= {rd_byte[6:0], 1'b0};
                miso_oe  <= 1'b1;
                addr     <= rd_addr;
                bit_cnt  <= '0;
              end else begin
                miso     <= rd_shift[7];
                rd_shift <= {rd_shift[6:0], 1'b0};
              end
            end
          end
          WR_DATA: if (sck_rise) begin
            shift_in <= in_byte[6:0];
            if (bit_cnt == BYTE_LAST) begin
              bit_cnt <= '0;
              addr    <= addr + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // SPI byte commit takes priority over the load port.
  always_ff @(posedge clk) begin
    if (spi_we)     mem[addr]    <= in_byte;
    else if (ld_we) mem[ld_addr] <= ld_data;
  end

endmodule
